hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage datapath. It produces the PC and IF/ID enables, the ID/EX bubble request, and the ID-stage forwarding selects that drive the operand muxes ahead of the ID/EX register. It also sequences the multi-cycle HI/LO multiply/divide unit so that dependent instructions wait in ID until the unit completes.

## Interface
Parameters:
- MDU_LAT, 4: multiply/divide latency in cycles; legal range 2..15.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs / rt.
- id_mdu_start  in  1  ID instruction is a mult/div.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- ex_rd, mem_rd, wb_rd  in  5 each  destination register in EX, MEM and WB.
- ex_rf_enable, mem_rf_enable, wb_rf_enable  in  1 each  stage writes the register file.
- ex_load  in  1  EX instruction is a load.
- pc_enable  out  1  PC may advance.
- ifid_enable  out  1  IF/ID may load.
- idex_nop  out  1  ID/EX loads all-zero control_signals (bubble).
- fwd_a, fwd_b  out  2 each  operand A/B source: 00 RF, 01 EX, 10 MEM, 11 WB.
- mdu_busy  out  1  multiply/divide in flight.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_enable=0.

## Operation
- Forwarding, evaluated per operand independently:
  - Match requires the src != 0, the uses_* bit =1, and the stage's rf_enable =1.
  - Priority is EX > MEM > WB; with no match the select is 00.
- Load-use hazard:
  - Condition: ex_load=1 and an EX match on a used source.
  - Response: stall=1.
- MDU hazard:
  - Condition: mdu_busy=1 and (id_reads_hilo or id_mdu_start).
  - Response: stall=1.
- Stall response: pc_enable=0, ifid_enable=0, idex_nop=1. Coincident hazards produce one stall, never more.
- FSM states:
  - RUN: mdu_busy=0. id_mdu_start with stall=0 loads cnt=MDU_LAT-1 and goes to MDU_BUSY.
  - MDU_BUSY: mdu_busy=1, cnt decrements each cycle. At cnt=0 the FSM returns to RUN; mdu_busy drops the following cycle.
- An mdu start is accepted only in a non-stall cycle. A start blocked by a load-use stall is accepted once the stall clears.
- stall_cycles increments on every cycle with pc_enable=0 and saturates at all-ones; it is cleared only by reset.

## Timing
- Reset values while reset=1: state RUN, cnt 0, mdu_busy 0, stall_cycles 0.
- With idle inputs: pc_enable 1, ifid_enable 1, idex_nop 0, fwd_a/fwd_b 00.
- pc_enable, ifid_enable, idex_nop and fwd_* are combinational from the inputs and current state, valid in the same cycle.
- Load-use costs exactly 1 bubble. The next cycle the load sits in MEM, and forwarding selects 10.
- An mdu start in cycle t: mdu_busy=1 in cycles t+1..t+MDU_LAT. A dependent mfhi stalls through t+MDU_LAT and advances in t+MDU_LAT+1.
- Reset asserted mid-MDU aborts the operation immediately: state RUN, mdu_busy 0.

## Configuration
- HAZARD_MDU_EN defined: MDU FSM, counter and MDU hazard are present as described.
- HAZARD_MDU_EN not defined:
  - FSM and counter are removed; mdu_busy is tied 0.
  - id_mdu_start and id_reads_hilo are ignored.
  - Only load-use stalls occur.

## Structure
- Shared pipeline package holds:
  - FWD_RF/FWD_EX/FWD_MEM/FWD_WB 2-bit constants.
  - hazard FSM state typedef (RUN, MDU_BUSY).
  - register-zero constant.
- One sub-module, fwd_select: purely combinational per-operand priority match, instantiated twice (A, B).
- Top level holds the stall logic, the FSM/counter and stall_cycles.

## Test plan
- Reset release, all inputs 0 -> pc_enable=1, ifid_enable=1, idex_nop=0, fwd_a=fwd_b=00, stall_cycles=0.
- Forwarding conflict: id_rs=5 with uses_rs; ex_rd=5, mem_rd=5, wb_rd=5, all rf_enable=1 -> fwd_a=01. Drop ex_rf_enable -> 10. Then set id_rs=0 -> fwd_a=00.
- Load-use: ex_load=1, ex_rd=8, id_rt=8 with uses_rt -> exactly one cycle of pc_enable=0 and idex_nop=1; next cycle mem_rd=8 -> fwd_b=10; stall_cycles=1.
- MDU_LAT=4, id_mdu_start at t, then mfhi in ID at t+1 -> stall t+1..t+4, advance t+5, mdu_busy low at t+5.
- Reset at t+2 of an MDU operation -> mdu_busy=0 immediately, no stall afterwards.
- Load-use coincident with mdu_busy: one stall; when both clear the pipeline advances in the same cycle. With HAZARD_MDU_EN undefined -> mdu_busy stays 0 and mfhi never stalls.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared forwarding selects, register-zero and hazard FSM state
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// rtl/hazard_ctrl_fwd_select.sv - per-operand forwarding priority match (EX > MEM > WB)
module fwd_select
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       uses,
  input  logic [4:0] ex_rd,
  input  logic       ex_rf_enable,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_enable,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_enable,
  output logic [1:0] sel,
  output logic       ex_match
);

  logic live;
  logic mem_match;
  logic wb_match;

  // r0 is hardwired to zero, so it never takes a forwarded value
  assign live      = uses && (src != REG_ZERO);
  assign ex_match  = live && ex_rf_enable  && (ex_rd  == src);
  assign mem_match = live && mem_rf_enable && (mem_rd == src);
  assign wb_match  = live && wb_rf_enable  && (wb_rd  == src);

  always_comb begin
    sel = FWD_RF;
    if (ex_match)       sel = FWD_EX;
    else if (mem_match) sel = FWD_MEM;
    else if (wb_match)  sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/forwarding control; HAZARD_MDU_EN adds the multiply/divide sequencer
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             id_reads_hilo,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic [4:0]       wb_rd,
  input  logic             ex_rf_enable,
  input  logic             mem_rf_enable,
  input  logic             wb_rf_enable,
  input  logic             ex_load,
  output logic             pc_enable,
  output logic             ifid_enable,
  output logic             idex_nop,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic ex_match_a;
  logic ex_match_b;
  logic load_use;
  logic mdu_hazard;
  logic stall;

  fwd_select u_fwd_a (
    .src(id_rs), .uses(id_uses_rs),
    .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable),
    .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
    .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
    .sel(fwd_a), .ex_match(ex_match_a)
  );

  fwd_select u_fwd_b (
    .src(id_rt), .uses(id_uses_rt),
    .ex_rd(ex_rd), .ex_rf_enable(ex_rf_enable),
    .mem_rd(mem_rd), .mem_rf_enable(mem_rf_enable),
    .wb_rd(wb_rd), .wb_rf_enable(wb_rf_enable),
    .sel(fwd_b), .ex_match(ex_match_b)
  );

  assign load_use    = ex_load && (ex_match_a || ex_match_b);
  assign stall       = load_use || mdu_hazard;
  assign pc_enable   = !stall;
  assign ifid_enable = !stall;
  assign idex_nop    = stall;

`ifdef HAZARD_MDU_EN
  localparam logic [3:0] LAT_M1 = 4'(MDU_LAT - 1);

  hz_state_e  state;
  hz_state_e  state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // a start held off by a load-use stall stays in ID and is taken once the stall clears
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (id_mdu_start && !stall) begin
          state_nxt = MDU_BUSY;
          cnt_nxt   = LAT_M1;
        end
      end
      MDU_BUSY: begin
        if (cnt == 4'd0) state_nxt = RUN;
        else             cnt_nxt   = cnt - 4'd1;
      end
    endcase
  end

  assign mdu_busy   = (state == MDU_BUSY);
  assign mdu_hazard = mdu_busy && (id_reads_hilo || id_mdu_start);
`else
  logic unused_mdu_inputs;

  assign unused_mdu_inputs = id_mdu_start ^ id_reads_hilo ^ (MDU_LAT == 0);
  assign mdu_busy          = 1'b0;
  assign mdu_hazard        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed checks of hazard_ctrl against a cycle-count model
module tb_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo;
  logic ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load;
  logic pc_enable, ifid_enable, idex_nop, mdu_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mdu_s    = -1000;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_mdu_start(id_mdu_start), .id_reads_hilo(id_reads_hilo),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
    .ex_load(ex_load),
    .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_nop(idex_nop),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic uses);
    if (!uses || src == 5'd0)            return 2'd0;
    if (ex_rf_enable  && ex_rd  == src)  return 2'd1;
    if (mem_rf_enable && mem_rd == src)  return 2'd2;
    if (wb_rf_enable  && wb_rd  == src)  return 2'd3;
    return 2'd0;
  endfunction

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_mdu_start = 0; id_reads_hilo = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_rf_enable = 0; mem_rf_enable = 0; wb_rf_enable = 0; ex_load = 0;
  endtask

  // called mid-cycle with inputs settled: compare, clock, advance the model
  task automatic step();
    logic busy_e, lu, st;
    busy_e = MDU_EN && (cyc >= mdu_s + 1) && (cyc <= mdu_s + LAT);
    lu = ex_load && ((ref_fwd(id_rs, id_uses_rs) == 2'd1) || (ref_fwd(id_rt, id_uses_rt) == 2'd1));
    st = lu || (busy_e && (id_reads_hilo || id_mdu_start));
    check("pc_enable",    32'(pc_enable),    32'(!st));
    check("ifid_enable",  32'(ifid_enable),  32'(!st));
    check("idex_nop",     32'(idex_nop),     32'(st));
    check("fwd_a",        32'(fwd_a),        32'(ref_fwd(id_rs, id_uses_rs)));
    check("fwd_b",        32'(fwd_b),        32'(ref_fwd(id_rt, id_uses_rt)));
    check("mdu_busy",     32'(mdu_busy),     32'(busy_e));
    check("stall_cycles", 32'(stall_cycles), 32'(stall_cnt));
    @(posedge clk);
    if (MDU_EN && !st && id_mdu_start) mdu_s = cyc;
    if (st && stall_cnt < SAT) stall_cnt++;
    cyc++;
    #1;
  endtask

  initial begin
    int stalls;
    bit advanced;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mdu_busy", 32'(mdu_busy), 32'd0);
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    reset = 1'b0;
    #4;
    check("idle_pc_enable", 32'(pc_enable), 32'd1);
    check("idle_idex_nop", 32'(idex_nop), 32'd0);
    check("idle_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    step();

    // forwarding priority
    id_rs = 5; id_uses_rs = 1; ex_rd = 5; mem_rd = 5; wb_rd = 5;
    ex_rf_enable = 1; mem_rf_enable = 1; wb_rf_enable = 1;
    #4; check("fwd_ex_prio", 32'(fwd_a), 32'd1); step();
    ex_rf_enable = 0;
    #4; check("fwd_mem_prio", 32'(fwd_a), 32'd2); step();
    mem_rf_enable = 0;
    #4; check("fwd_wb", 32'(fwd_a), 32'd3); step();
    id_rs = 0; ex_rf_enable = 1; mem_rf_enable = 1;
    #4; check("fwd_r0", 32'(fwd_a), 32'd0); step();

    // load-use: one bubble, then MEM forward
    idle();
    ex_load = 1; ex_rd = 8; ex_rf_enable = 1; id_rt = 8; id_uses_rt = 1;
    #4;
    check("lu_pc_enable", 32'(pc_enable), 32'd0);
    check("lu_idex_nop", 32'(idex_nop), 32'd1);
    step();
    ex_load = 0; ex_rd = 0; ex_rf_enable = 0; mem_rd = 8; mem_rf_enable = 1;
    #4;
    check("lu_fwd_mem", 32'(fwd_b), 32'd2);
    check("lu_advance", 32'(pc_enable), 32'd1);
    check("lu_stall_cycles", 32'(stall_cycles), 32'd1);
    step();

    // MDU start followed by dependent mfhi
    idle();
    id_mdu_start = 1;
    #4; step();
    id_mdu_start = 0; id_reads_hilo = 1;
    stalls = 0; advanced = 0;
    for (int i = 0; i < 20; i++) begin
      #4;
      if (pc_enable) begin advanced = 1; break; end
      stalls++;
      step();
    end
    check("mdu_advanced", 32'(advanced), 32'd1);
    check("mdu_stall_len", 32'(stalls), MDU_EN ? 32'(LAT) : 32'd0);
    check("mdu_busy_low", 32'(mdu_busy), 32'd0);
    step();

    // reset in the middle of an MDU operation
    idle();
    id_mdu_start = 1;
    #4; step();
    id_mdu_start = 0;
    #4; step();
    id_reads_hilo = 1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(mdu_busy), 32'd0);
    check("mid_rst_pc_enable", 32'(pc_enable), 32'd1);
    mdu_s = -1000; stall_cnt = 0;
    #2; reset = 1'b0; #1;
    step();
    #4; step();

    // load-use coincident with the last busy cycle
    idle();
    id_mdu_start = 1;
    #4; step();
    id_mdu_start = 0; id_reads_hilo = 1;
    stalls = 0;
    for (int i = 1; i <= LAT; i++) begin
      if (i == LAT) begin ex_load = 1; ex_rd = 9; ex_rf_enable = 1; id_rs = 9; id_uses_rs = 1; end
      #4;
      if (!pc_enable) stalls++;
      step();
    end
    check("coinc_stalls", 32'(stalls), MDU_EN ? 32'(LAT) : 32'd1);
    ex_load = 0; ex_rd = 0; mem_rd = 9; mem_rf_enable = 1; ex_rf_enable = 0;
    #4;
    check("coinc_advance", 32'(pc_enable), 32'd1);
    step();

    // randomized traffic over a small register window to force matches
    for (int i = 0; i < 300; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
      ex_rf_enable = 1'($urandom); mem_rf_enable = 1'($urandom); wb_rf_enable = 1'($urandom);
      ex_load = ($urandom_range(0, 3) == 0);
      id_mdu_start = ($urandom_range(0, 7) == 0);
      id_reads_hilo = ($urandom_range(0, 3) == 0);
      #4; step();
    end

    // counter saturation
    idle();
    ex_load = 1; ex_rd = 4; ex_rf_enable = 1; id_rs = 4; id_uses_rs = 1;
    for (int i = 0; i < SAT + 5; i++) begin #4; step(); end
    #4;
    check("stall_sat", 32'(stall_cycles), 32'(SAT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
